// File: rtl/mog_pkg.sv
// Shared definitions for the Mixture-of-Gaussians pipeline: parameter bundle
// layout, mask word geometry and the write-back packer state encoding.
package mog_pkg;

  localparam int PARAM_W  = 32;
  localparam int N_GAUSS  = 3;
  localparam int BUNDLE_W = PARAM_W * 3 * N_GAUSS;

  // Bundle layout {w3,sd3,mean3,w2,sd2,mean2,w1,sd1,mean1}, mean1 at bit 0
  localparam int MEAN1_LSB = 0;
  localparam int SD1_LSB   = 32;
  localparam int W1_LSB    = 64;
  localparam int MEAN2_LSB = 96;
  localparam int SD2_LSB   = 128;
  localparam int W2_LSB    = 160;
  localparam int MEAN3_LSB = 192;
  localparam int SD3_LSB   = 224;
  localparam int W3_LSB    = 256;

  localparam int MASK_W     = 32;
  localparam int MASK_IDX_W = 5;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } wb_state_e;

  // One-hot placement of a foreground flag at its bit slot in a mask word.
  function automatic logic [MASK_W-1:0] fg_bit(input logic fg, input logic [MASK_IDX_W-1:0] idx);
    fg_bit = {{(MASK_W-1){1'b0}}, fg} << idx;
  endfunction

endpackage

// File: rtl/mog_sync_fifo.sv
// Synchronous FIFO with registered empty/not-full flags; a push and a pop may
// complete in the same cycle, but a push is never taken while full.
module mog_sync_fifo #(
  parameter int WIDTH = 289,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             not_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             empty_r;
  logic             not_full_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_SLOT) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign do_push_s = push && not_full_r;
  assign do_pop_s  = pop && !empty_r;

  // Occupancy after this cycle's push/pop
  always_comb begin
    cnt_next_s = cnt_r;
    if (do_push_s && !do_pop_s) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      cnt_next_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      empty_r    <= 1'b1;
      not_full_r <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      cnt_r      <= cnt_next_s;
      empty_r    <= (cnt_next_s == {CNT_W{1'b0}});
      not_full_r <= (cnt_next_s != FULL_CNT);
    end
  end

  assign rdata    = mem_r[rd_ptr_r];
  assign empty    = empty_r;
  assign not_full = not_full_r;

endmodule

// File: rtl/mog_writeback.sv
// MoG write-back stage: buffers detected pixels, emits per-pixel parameter
// records and 32-pixel packed foreground-mask words with frame-relative addresses.
module mog_writeback
  import mog_pkg::*;
#(
  parameter int PIX_PER_FRAME = 76800,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_W        = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         is_fg,
  input  logic [BUNDLE_W-1:0]          param_in,
  output logic                         prm_valid,
  input  logic                         prm_ready,
  output logic [ADDR_W-1:0]            prm_addr,
  output logic [BUNDLE_W-1:0]          prm_data,
  output logic                         mask_valid,
  input  logic                         mask_ready,
  output logic [ADDR_W-MASK_IDX_W-1:0] mask_addr,
  output logic [MASK_W-1:0]            mask_data,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int FIFO_W = BUNDLE_W + 1;
  localparam int WORD_W = ADDR_W - MASK_IDX_W;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_PER_FRAME - 1);

  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fifo_empty_s;
  logic                  fifo_not_full_s;
  logic [FIFO_W-1:0]     fifo_rdata_s;
  logic                  pop_fg_s;
  logic [BUNDLE_W-1:0]   pop_data_s;
  logic                  last_pix_s;
  logic                  word_done_s;
  logic                  load_word_s;
  logic                  mask_fire_s;
  logic [MASK_W-1:0]     acc_next_s;

  logic [ADDR_W-1:0]     pix_cnt_r;
  logic [MASK_W-1:0]     acc_r;
  wb_state_e             state_r;
  logic                  prm_valid_r;
  logic [ADDR_W-1:0]     prm_addr_r;
  logic [BUNDLE_W-1:0]   prm_data_r;
  logic [WORD_W-1:0]     mask_addr_r;
  logic [MASK_W-1:0]     mask_data_r;
  logic                  mask_last_r;
  logic                  frame_done_r;
  logic                  overflow_r;

  // in_ready is the FIFO's registered not-full flag, so a full FIFO refuses
  // a push even when a pop frees a slot in the same cycle.
  assign fifo_push_s = in_valid && fifo_not_full_s;

  mog_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push_s),
    .wdata    ({is_fg, param_in}),
    .pop      (fifo_pop_s),
    .rdata    (fifo_rdata_s),
    .empty    (fifo_empty_s),
    .not_full (fifo_not_full_s)
  );

  // Pop arbitration and packer next-state
  always_comb begin
    pop_fg_s    = fifo_rdata_s[FIFO_W-1];
    pop_data_s  = fifo_rdata_s[BUNDLE_W-1:0];
    last_pix_s  = (pix_cnt_r == LAST_PIX);
    word_done_s = (pix_cnt_r[MASK_IDX_W-1:0] == {MASK_IDX_W{1'b1}}) || last_pix_s;
    mask_fire_s = (state_r == HOLD) && mask_ready;
    // A word-completing pixel waits only while the previous word is still unaccepted
    fifo_pop_s  = !fifo_empty_s
                  && (!prm_valid_r || prm_ready)
                  && !(word_done_s && (state_r == HOLD) && !mask_ready);
    load_word_s = fifo_pop_s && word_done_s;
    acc_next_s  = acc_r | fg_bit(pop_fg_s, pix_cnt_r[MASK_IDX_W-1:0]);
  end

  // Sticky drop flag for beats offered while the FIFO is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (in_valid && !fifo_not_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Pixel counter and mask accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_r <= {ADDR_W{1'b0}};
      acc_r     <= {MASK_W{1'b0}};
    end else if (fifo_pop_s) begin
      pix_cnt_r <= last_pix_s ? {ADDR_W{1'b0}} : (pix_cnt_r + ADDR_W'(1));
      acc_r     <= word_done_s ? {MASK_W{1'b0}} : acc_next_s;
    end
  end

  // Parameter write-back record register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prm_valid_r <= 1'b0;
      prm_addr_r  <= {ADDR_W{1'b0}};
      prm_data_r  <= {BUNDLE_W{1'b0}};
    end else if (fifo_pop_s) begin
      prm_valid_r <= 1'b1;
      prm_addr_r  <= pix_cnt_r;
      prm_data_r  <= pop_data_s;
    end else if (prm_ready) begin
      prm_valid_r <= 1'b0;
    end
  end

  // Mask word output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_addr_r <= {WORD_W{1'b0}};
      mask_data_r <= {MASK_W{1'b0}};
      mask_last_r <= 1'b0;
    end else if (load_word_s) begin
      mask_addr_r <= pix_cnt_r[ADDR_W-1:MASK_IDX_W];
      mask_data_r <= acc_next_s;
      mask_last_r <= last_pix_s;
    end
  end

  // Mask handshake FSM: HOLD while a loaded word awaits mask_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      case (state_r)
        ACCUM: state_r <= load_word_s ? HOLD : ACCUM;
        HOLD: begin
          if (load_word_s) begin
            state_r <= HOLD;
          end else if (mask_ready) begin
            state_r <= ACCUM;
          end else begin
            state_r <= HOLD;
          end
        end
        default: state_r <= ACCUM;
      endcase
    end
  end

  // Frame completion pulse after the last word of the frame is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= mask_fire_s && mask_last_r;
    end
  end

  assign in_ready   = fifo_not_full_s;
  assign prm_valid  = prm_valid_r;
  assign prm_addr   = prm_addr_r;
  assign prm_data   = prm_data_r;
  assign mask_valid = (state_r == HOLD);
  assign mask_addr  = mask_addr_r;
  assign mask_data  = mask_data_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_mog_writeback.sv
// Directed bench for mog_writeback with a 40-pixel frame: streaming, mask
// back-pressure, record back-pressure, overflow, back-to-back frames, mid-frame reset.
module tb_mog_writeback;

  localparam int PPF = 40;
  localparam int AW  = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         is_fg = 1'b0;
  logic [287:0] param_in = '0;
  logic         prm_ready = 1'b1;
  logic         mask_ready = 1'b1;
  logic         in_ready;
  logic         prm_valid;
  logic [16:0]  prm_addr;
  logic [287:0] prm_data;
  logic         mask_valid;
  logic [11:0]  mask_addr;
  logic [31:0]  mask_data;
  logic         frame_done;
  logic         overflow;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int stab_err = 0;

  logic [16:0]  prm_addr_q[$];
  logic [287:0] prm_data_q[$];
  int           prm_cyc_q[$];
  logic [11:0]  mask_addr_q[$];
  logic [31:0]  mask_data_q[$];
  int           mask_cyc_q[$];
  int           fd_cyc_q[$];

  logic         prm_hold = 1'b0;
  logic [16:0]  prm_addr_h = '0;
  logic [287:0] prm_data_h = '0;
  logic         mask_hold = 1'b0;
  logic [11:0]  mask_addr_h = '0;
  logic [31:0]  mask_data_h = '0;

  mog_writeback #(.PIX_PER_FRAME(PPF), .FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .is_fg(is_fg), .param_in(param_in),
    .prm_valid(prm_valid), .prm_ready(prm_ready), .prm_addr(prm_addr), .prm_data(prm_data),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_addr(mask_addr), .mask_data(mask_data),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs handshakes and checks valid/data stability under back-pressure
  always @(negedge clk) begin
    int bad;
    bad = 0;
    if (rst) begin
      prm_hold  <= 1'b0;
      mask_hold <= 1'b0;
    end else begin
      if (prm_valid && prm_ready) begin
        prm_addr_q.push_back(prm_addr);
        prm_data_q.push_back(prm_data);
        prm_cyc_q.push_back(cyc);
      end
      if (mask_valid && mask_ready) begin
        mask_addr_q.push_back(mask_addr);
        mask_data_q.push_back(mask_data);
        mask_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc_q.push_back(cyc);
      end
      if (prm_hold && (!prm_valid || prm_addr !== prm_addr_h || prm_data !== prm_data_h)) bad++;
      if (mask_hold && (!mask_valid || mask_addr !== mask_addr_h || mask_data !== mask_data_h)) bad++;
      stab_err    <= stab_err + bad;
      prm_hold    <= prm_valid && !prm_ready;
      prm_addr_h  <= prm_addr;
      prm_data_h  <= prm_data;
      mask_hold   <= mask_valid && !mask_ready;
      mask_addr_h <= mask_addr;
      mask_data_h <= mask_data;
    end
  end

  function automatic logic [287:0] pdata(input int f, input int idx);
    logic [287:0] d;
    for (int k = 0; k < 9; k++) d[k*32 +: 32] = {8'(f), 8'(k), 16'(idx)};
    return d;
  endfunction

  task automatic clear_q;
    prm_addr_q.delete(); prm_data_q.delete(); prm_cyc_q.delete();
    mask_addr_q.delete(); mask_data_q.delete(); mask_cyc_q.delete(); fd_cyc_q.delete();
  endtask

  task automatic do_reset;
    in_valid = 1'b0; prm_ready = 1'b1; mask_ready = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; offers one beat only while in_ready is high
  task automatic send(input int f, input int idx, input logic fg);
    int guard;
    guard = 0;
    while (!in_ready && guard < 400) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end else begin
      in_valid = 1'b1; is_fg = fg; param_in = pdata(f, idx);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (prm_valid !== 1'b0) begin n_fail++; $display("FAIL rst_prm_valid: got %0b want 0", prm_valid); end
    n_cmp++; if (mask_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mask_valid: got %0b want 0", mask_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %0b want 0", frame_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    n_cmp++; if (prm_addr !== 17'd0) begin n_fail++; $display("FAIL rst_prm_addr: got %0d want 0", prm_addr); end
    n_cmp++; if (mask_data !== 32'd0) begin n_fail++; $display("FAIL rst_mask_data: got %h want 0", mask_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    int fd0;
    do_reset();
    fd0 = fd_cnt;
    for (int i = 0; i < PPF; i++) send(1, i, (i % 2) == 1);
    idle(20);
    n_cmp++; if (prm_addr_q.size() !== PPF) begin n_fail++; $display("FAIL stream_prm_count: got %0d want %0d", prm_addr_q.size(), PPF); end
    for (int i = 0; i < PPF && i < prm_addr_q.size(); i++) begin
      n_cmp++; if (prm_addr_q[i] !== 17'(i)) begin n_fail++; $display("FAIL stream_prm_addr[%0d]: got %0d want %0d", i, prm_addr_q[i], i); end
      n_cmp++; if (prm_data_q[i] !== pdata(1, i)) begin n_fail++; $display("FAIL stream_prm_data[%0d]: got %h want %h", i, prm_data_q[i], pdata(1, i)); end
      n_cmp++; if (prm_cyc_q[i] !== prm_cyc_q[0] + i) begin n_fail++; $display("FAIL stream_rate[%0d]: got cycle %0d want %0d", i, prm_cyc_q[i], prm_cyc_q[0] + i); end
    end
    n_cmp++; if (mask_data_q.size() !== 2) begin n_fail++; $display("FAIL stream_mask_count: got %0d want 2", mask_data_q.size()); end
    if (mask_data_q.size() >= 2) begin
      n_cmp++; if (mask_addr_q[0] !== 12'd0) begin n_fail++; $display("FAIL stream_mask_addr0: got %0d want 0", mask_addr_q[0]); end
      n_cmp++; if (mask_data_q[0] !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL stream_mask_data0: got %h want aaaaaaaa", mask_data_q[0]); end
      n_cmp++; if (mask_addr_q[1] !== 12'd1) begin n_fail++; $display("FAIL stream_mask_addr1: got %0d want 1", mask_addr_q[1]); end
      n_cmp++; if (mask_data_q[1] !== 32'h0000_00AA) begin n_fail++; $display("FAIL stream_mask_data1: got %h want 000000aa", mask_data_q[1]); end
    end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL stream_fd_count: got %0d want 1", fd_cnt - fd0); end
    if (fd_cyc_q.size() >= 1 && mask_cyc_q.size() >= 2) begin
      n_cmp++; if (fd_cyc_q[0] !== mask_cyc_q[1] + 1) begin n_fail++; $display("FAIL stream_fd_timing: got cycle %0d want %0d", fd_cyc_q[0], mask_cyc_q[1] + 1); end
    end
  endtask

  task automatic test_mask_stall;
    int fd0;
    bit seen;
    do_reset();
    fd0 = fd_cnt;
    mask_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < PPF; i++) send(1, i, (i % 2) == 1);
        for (int i = 0; i < 8; i++) send(2, i, (i % 2) == 1);
        in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
          @(negedge clk);
          if (!in_ready) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL stall_in_ready_fall: in_ready never 0, want 0"); end
        n_cmp++; if (prm_addr_q.size() !== 39) begin n_fail++; $display("FAIL stall_prm_before_release: got %0d records want 39", prm_addr_q.size()); end
        n_cmp++; if (mask_valid !== 1'b1) begin n_fail++; $display("FAIL stall_mask_valid: got %0b want 1", mask_valid); end
        n_cmp++; if (mask_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL stall_mask_data: got %h want aaaaaaaa", mask_data); end
        n_cmp++; if (mask_data_q.size() !== 0) begin n_fail++; $display("FAIL stall_mask_taken: got %0d words want 0", mask_data_q.size()); end
        repeat (3) @(posedge clk);
        #1 mask_ready = 1'b1;
      end
    join
    idle(20);
    n_cmp++; if (prm_addr_q.size() !== PPF + 8) begin n_fail++; $display("FAIL stall_prm_count: got %0d want %0d", prm_addr_q.size(), PPF + 8); end
    for (int i = 0; i < PPF + 8 && i < prm_addr_q.size(); i++) begin
      int f, idx;
      f = (i < PPF) ? 1 : 2;
      idx = (i < PPF) ? i : i - PPF;
      n_cmp++; if (prm_addr_q[i] !== 17'(idx)) begin n_fail++; $display("FAIL stall_prm_addr[%0d]: got %0d want %0d", i, prm_addr_q[i], idx); end
      n_cmp++; if (prm_data_q[i] !== pdata(f, idx)) begin n_fail++; $display("FAIL stall_prm_data[%0d]: got %h want %h", i, prm_data_q[i], pdata(f, idx)); end
    end
    n_cmp++; if (mask_data_q.size() !== 2) begin n_fail++; $display("FAIL stall_mask_count: got %0d want 2", mask_data_q.size()); end
    if (mask_data_q.size() >= 2) begin
      n_cmp++; if (mask_data_q[0] !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL stall_mask_data0: got %h want aaaaaaaa", mask_data_q[0]); end
      n_cmp++; if (mask_data_q[1] !== 32'h0000_00AA || mask_addr_q[1] !== 12'd1) begin n_fail++; $display("FAIL stall_mask_word1: got %h@%0d want 000000aa@1", mask_data_q[1], mask_addr_q[1]); end
    end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL stall_fd_count: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_prm_toggle;
    int st0;
    bit tog_done;
    do_reset();
    st0 = stab_err;
    tog_done = 1'b0;
    fork
      begin
        for (int i = 0; i < PPF; i++) send(1, i, (i % 2) == 1);
        idle(100);
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          @(posedge clk); #1;
          prm_ready = ~prm_ready;
        end
      end
    join
    prm_ready = 1'b1;
    idle(10);
    n_cmp++; if (stab_err - st0 !== 0) begin n_fail++; $display("FAIL toggle_stability: got %0d violations want 0", stab_err - st0); end
    n_cmp++; if (prm_addr_q.size() !== PPF) begin n_fail++; $display("FAIL toggle_prm_count: got %0d want %0d", prm_addr_q.size(), PPF); end
    for (int i = 0; i < PPF && i < prm_addr_q.size(); i++) begin
      n_cmp++; if (prm_addr_q[i] !== 17'(i) || prm_data_q[i] !== pdata(1, i)) begin n_fail++; $display("FAIL toggle_prm[%0d]: got addr %0d want %0d", i, prm_addr_q[i], i); end
    end
    n_cmp++; if (mask_data_q.size() !== 2) begin n_fail++; $display("FAIL toggle_mask_count: got %0d want 2", mask_data_q.size()); end
    if (mask_data_q.size() >= 2) begin
      n_cmp++; if (mask_data_q[0] !== 32'hAAAA_AAAA || mask_data_q[1] !== 32'h0000_00AA) begin n_fail++; $display("FAIL toggle_mask_data: got %h,%h want aaaaaaaa,000000aa", mask_data_q[0], mask_data_q[1]); end
    end
  endtask

  task automatic test_overflow;
    do_reset();
    prm_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1, i, (i % 2) == 1);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full: in_ready got %0b want 0", in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %0b want 0", overflow); end
    in_valid = 1'b1; is_fg = 1'b1; param_in = pdata(9, 99);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    prm_ready = 1'b1;
    for (int i = 5; i < PPF; i++) send(1, i, (i % 2) == 1);
    idle(20);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    n_cmp++; if (prm_addr_q.size() !== PPF) begin n_fail++; $display("FAIL ovf_prm_count: got %0d want %0d", prm_addr_q.size(), PPF); end
    for (int i = 0; i < PPF && i < prm_addr_q.size(); i++) begin
      n_cmp++; if (prm_addr_q[i] !== 17'(i) || prm_data_q[i] !== pdata(1, i)) begin n_fail++; $display("FAIL ovf_prm[%0d]: got addr %0d data %h want addr %0d", i, prm_addr_q[i], prm_data_q[i][31:0], i); end
    end
    n_cmp++; if (mask_data_q.size() !== 2) begin n_fail++; $display("FAIL ovf_mask_count: got %0d want 2", mask_data_q.size()); end
    if (mask_data_q.size() >= 1) begin
      n_cmp++; if (mask_data_q[0] !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL ovf_mask_data0: got %h want aaaaaaaa", mask_data_q[0]); end
    end
  endtask

  task automatic test_back_to_back;
    int fd0;
    do_reset();
    fd0 = fd_cnt;
    for (int i = 0; i < 2 * PPF; i++) send(1 + i / PPF, i % PPF, ((i % PPF) % 2) == 1);
    idle(20);
    n_cmp++; if (prm_addr_q.size() !== 2 * PPF) begin n_fail++; $display("FAIL b2b_prm_count: got %0d want %0d", prm_addr_q.size(), 2 * PPF); end
    for (int i = 0; i < 2 * PPF && i < prm_addr_q.size(); i++) begin
      n_cmp++; if (prm_addr_q[i] !== 17'(i % PPF) || prm_data_q[i] !== pdata(1 + i / PPF, i % PPF)) begin n_fail++; $display("FAIL b2b_prm[%0d]: got addr %0d want %0d", i, prm_addr_q[i], i % PPF); end
    end
    n_cmp++; if (mask_data_q.size() !== 4) begin n_fail++; $display("FAIL b2b_mask_count: got %0d want 4", mask_data_q.size()); end
    for (int k = 0; k < 4 && k < mask_data_q.size(); k++) begin
      logic [31:0] exp_w;
      exp_w = (k % 2 == 0) ? 32'hAAAA_AAAA : 32'h0000_00AA;
      n_cmp++; if (mask_addr_q[k] !== 12'(k % 2) || mask_data_q[k] !== exp_w) begin n_fail++; $display("FAIL b2b_mask[%0d]: got %h@%0d want %h@%0d", k, mask_data_q[k], mask_addr_q[k], exp_w, k % 2); end
    end
    n_cmp++; if (fd_cnt - fd0 !== 2) begin n_fail++; $display("FAIL b2b_fd_count: got %0d want 2", fd_cnt - fd0); end
  endtask

  task automatic test_mid_reset;
    int fd0;
    do_reset();
    for (int i = 0; i < 20; i++) send(3, i, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (prm_valid !== 1'b0 || prm_addr !== 17'd0 || prm_data !== 288'd0) begin n_fail++; $display("FAIL midrst_prm: got valid %0b addr %0d want 0/0", prm_valid, prm_addr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (mask_valid !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got mv %0b fd %0b ov %0b want 0", mask_valid, frame_done, overflow); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    fd0 = fd_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < PPF; i++) send(4, i, (i % 2) == 1);
    idle(20);
    n_cmp++; if (prm_addr_q.size() !== PPF) begin n_fail++; $display("FAIL midrst_prm_count: got %0d want %0d", prm_addr_q.size(), PPF); end
    if (prm_addr_q.size() >= 1) begin
      n_cmp++; if (prm_addr_q[0] !== 17'd0 || prm_data_q[0] !== pdata(4, 0)) begin n_fail++; $display("FAIL midrst_first_prm: got addr %0d want 0", prm_addr_q[0]); end
    end
    n_cmp++; if (mask_data_q.size() !== 2) begin n_fail++; $display("FAIL midrst_mask_count: got %0d want 2", mask_data_q.size()); end
    if (mask_data_q.size() >= 1) begin
      n_cmp++; if (mask_addr_q[0] !== 12'd0 || mask_data_q[0] !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL midrst_mask0: got %h@%0d want aaaaaaaa@0", mask_data_q[0], mask_addr_q[0]); end
    end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL midrst_fd_count: got %0d want 1", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask_stall();
    test_prm_toggle();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
